// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helper for the MixColumns stage.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Upstream (ShiftRows) and downstream (AddRoundKey) handshakes of mix_columns_seq.
interface mix_columns_seq_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   in_bypass;
  logic   in_inv;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport slave (
    input  in_valid, in_state, in_bypass, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, in_bypass, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

endinterface

// File: rtl/mix_col_word.sv
// Combinational (Inv)MixColumns of one 32-bit column; row 0 is the MSB byte.
// Inverse matrix is built only when MIX_COL_INV_EN is defined.
module mix_col_word
  import aes_pkg::*;
(
  input  col_t col_in,
  input  logic inv,
  output col_t col_out
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  col_t       fwd_col;
  col_t       inv_col;

  // inverse coefficients: 9=8+1, B=8+2+1, D=8+4+1, E=8+4+2
  always_comb begin
    fwd_col = '0;
    inv_col = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col_in[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      fwd_col[31-8*i -: 8] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      inv_col[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                           ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                           ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                           ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
  end

`ifdef MIX_COL_INV_EN
  assign col_out = inv ? inv_col : fwd_col;
`else
  logic  unused_inv;
  col_t  unused_inv_col;
  assign unused_inv     = inv;
  assign unused_inv_col = inv_col;
  assign col_out        = fwd_col;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per clock, single state buffer, bypass for
// the final round. Define MIX_COL_INV_EN to include the InvMixColumns datapath.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mix_columns_seq_if.slave   bus,
  output logic               busy
);

  mc_state_e state_q, state_d;
  state_t    state_buf;
  state_t    buf_nxt;
  logic [1:0] col_idx;
  col_t      cur_col;
  col_t      mixed_col;
  logic      inv_q;
  logic      accept;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = bus.in_bypass ? ST_DONE : ST_CALC;
      ST_CALC: if (col_idx == 2'd3) state_d = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = bus.in_bypass ? ST_DONE : ST_CALC;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // out_state is zero outside DONE so a partially mixed buffer never leaks out
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    bus.out_valid = (state_q == ST_DONE);
    bus.out_state = (state_q == ST_DONE) ? state_buf : '0;
    busy          = (state_q == ST_CALC) || (state_q == ST_DONE);
  end

  always_comb begin
    buf_nxt = state_buf;
    cur_col = '0;
    unique case (col_idx)
      2'd0: begin cur_col = state_buf[127:96]; buf_nxt[127:96] = mixed_col; end
      2'd1: begin cur_col = state_buf[95:64];  buf_nxt[95:64]  = mixed_col; end
      2'd2: begin cur_col = state_buf[63:32];  buf_nxt[63:32]  = mixed_col; end
      default: begin cur_col = state_buf[31:0]; buf_nxt[31:0] = mixed_col; end
    endcase
  end

  mix_col_word u_mix_col_word (
    .col_in  (cur_col),
    .inv     (inv_q),
    .col_out (mixed_col)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_buf <= '0;
      col_idx   <= '0;
    end else if (accept) begin
      state_buf <= bus.in_state;
      col_idx   <= '0;
    end else if (state_q == ST_CALC) begin
      state_buf <= buf_nxt;
      col_idx   <= col_idx + 2'd1;
    end
  end

`ifdef MIX_COL_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= bus.in_inv;
  end
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;
  assign inv_q         = 1'b0;
`endif

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: known vectors, latency, backpressure,
// back-to-back, bypass throughput, random transfers and reset mid-CALC.
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  state_t exp_q[$];

  mix_columns_seq_if bus_if ();

  mix_columns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic state_t mdl_mix(input state_t s, input logic inv);
    logic [7:0] cf [4];
    logic [7:0] r;
    state_t o = '0;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++)
          r = r ^ gmul(s[127-32*c-8*j -: 8], cf[(j+4-i)%4]);
        o[127-32*c-8*i -: 8] = r;
      end
    return o;
  endfunction

  function automatic logic inv_eff(input logic inv);
`ifdef MIX_COL_INV_EN
    return inv;
`else
    return 1'b0 & inv;
`endif
  endfunction

  // Output monitor: a beat transfers when out_valid && out_ready at the next edge
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_out", bus_if.out_state, 128'd0 + 128'(exp_q.size()));
      else                   chk("sb_out_state", bus_if.out_state, exp_q.pop_front());
    end
  end

  task automatic send(input state_t s, input logic byp, input logic inv, input state_t exp);
    int n = 0;
    bus_if.in_state  = s;
    bus_if.in_bypass = byp;
    bus_if.in_inv    = inv;
    bus_if.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus_if.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.in_ready) chk("accept_timeout", 128'(bus_if.in_ready), 128'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    while (!bus_if.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t vec_a, lit_a, vec_b, vec_i, exp_i, s, e;
    logic   byp, inv;
    int     c0, n;
    vec_a = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    lit_a = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    vec_b = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    vec_i = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
`ifdef MIX_COL_INV_EN
    exp_i = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
`else
    exp_i = mdl_mix(vec_i, 1'b0);
`endif

    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_state  = '0;
    bus_if.in_bypass = 1'b0;
    bus_if.in_inv    = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    chk("rst_out_state", bus_if.out_state, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(bus_if.in_ready), 128'd1);

    // known forward vector, literal expectation
    send(vec_a, 1'b0, 1'b0, lit_a);
    wait_valid("lat_mix", 5);
    @(posedge clk); #1;

    send(vec_b, 1'b1, 1'b0, vec_b);
    wait_valid("lat_bypass", 1);
    @(posedge clk); #1;

    // backpressure, then back-to-back accept in the release cycle
    bus_if.out_ready = 1'b0;
    s = 128'h00112233_44556677_8899aabb_ccddeeff;
    e = mdl_mix(s, 1'b0);
    send(s, 1'b0, 1'b0, e);
    wait_valid("lat_bp", 5);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("bp_hold_state", bus_if.out_state, e);
      chk("bp_hold_valid", 128'(bus_if.out_valid), 128'd1);
    end
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    s = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
    bus_if.in_state  = s;
    bus_if.in_bypass = 1'b0;
    bus_if.in_valid  = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 128'(bus_if.in_ready), 128'd1);
    @(posedge clk);
    exp_q.push_back(mdl_mix(s, 1'b0));
    #1;
    bus_if.in_valid = 1'b0;
    chk("calc_in_ready", 128'(bus_if.in_ready), 128'd0);
    chk("calc_busy", 128'(busy), 128'd1);
    wait_valid("lat_b2b", 5);
    @(posedge clk); #1;

    send(vec_i, 1'b0, 1'b1, exp_i);
    wait_valid("lat_inv", 5);
    @(posedge clk); #1;

    // bypass at one state per cycle
    c0 = cyc;
    send(128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 1'b0, 128'h01234567_89abcdef_fedcba98_76543210);
    send(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0, 128'h11111111_22222222_33333333_44444444);
    send(128'hdeadbeef_cafef00d_0badc0de_5a5aa5a5, 1'b1, 1'b0, 128'hdeadbeef_cafef00d_0badc0de_5a5aa5a5);
    chk("bypass_tput_cycles", 128'(cyc - c0), 128'd3);
    wait_valid("lat_bypass_tput", 1);
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      byp = 1'($urandom_range(0, 1));
      inv = 1'($urandom_range(0, 1));
      e   = byp ? s : mdl_mix(s, inv_eff(inv));
      send(s, byp, inv, e);
      wait_valid("lat_rand", byp ? 1 : 5);
      @(posedge clk); #1;
    end

    // reset during second CALC cycle discards the in-flight state
    send(vec_b, 1'b0, 1'b0, 128'd0);
    @(posedge clk); #2;
    chk("pre_rst_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_valid", 128'(bus_if.out_valid), 128'd0);
    chk("midrst_out_state", bus_if.out_state, 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 128'(bus_if.in_ready), 128'd1);
    send(vec_a, 1'b0, 1'b0, lit_a);
    wait_valid("lat_post_rst", 5);
    @(posedge clk); #1;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
